// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: sequencer state encoding and the per-stage
// stall/flush bundle driven into the 5-stage pipeline registers.
package pipe_pkg;

   localparam int PIPE_DEPTH_DEF = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic stallF;
      logic stallD;
      logic stallE;
      logic stallM;
      logic flushD;
      logic flushE;
      logic flushW;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_NONE = '0;

   // Whole front of the pipe frozen, bubble pushed into WB while memory is busy.
   function automatic stage_ctrl_t ctrl_mem_freeze();
      stage_ctrl_t c;
      c        = CTRL_NONE;
      c.stallF = 1'b1;
      c.stallD = 1'b1;
      c.stallE = 1'b1;
      c.stallM = 1'b1;
      c.flushW = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait cycle counter with timeout compare; reusable for any bus wait
// (data memory here, instruction fetch elsewhere).
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   input  logic clear_i,
   input  logic tick_i,
   output logic expired_o
);

   localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

   logic [TMO_W-1:0] cnt_q, cnt_d;

   // Clear beats start beats tick; start counts the entry cycle as the first wait.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (start_i) begin
         cnt_d = TMO_W'(1);
      end else if (tick_i) begin
         cnt_d = cnt_q + TMO_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == TMO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: merges hazard, data-memory wait and debug halt/drain/resume
// into per-stage stall/flush controls. Perf counters exist only with PIPE_SEQ_PERF_CNT_EN.
module pipeline_sequencer
   import pipe_pkg::*;
#(
   parameter int PIPE_DEPTH  = PIPE_DEPTH_DEF,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        loadUseE,
   input  logic        flushBranch,
   input  logic        dmemReqM,
   input  logic        dmemReady,
   input  logic        haltReq,
   input  logic        resumeReq,
   output logic        stallF,
   output logic        stallD,
   output logic        stallE,
   output logic        stallM,
   output logic        flushD,
   output logic        flushE,
   output logic        flushW,
   output logic        halted,
   output logic        busErr,
   output logic [31:0] perfStall,
   output logic [31:0] perfFlush
);

   localparam int DRN_W = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH - 1) : 1;
   localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(PIPE_DEPTH - 2);

   seq_state_t       state_q, state_d;
   logic [DRN_W-1:0] drain_q, drain_d;
   logic             from_drain_q, from_drain_d;
   logic             halted_q, halted_d;
   logic             busErr_q, busErr_d;
   logic             tmr_start, tmr_clear, tmr_tick, tmr_expired;
   logic             mem_miss;
   stage_ctrl_t      ctrl;

   assign mem_miss = dmemReqM && !dmemReady;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_dmem_timer (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .start_i   (tmr_start),
      .clear_i   (tmr_clear),
      .tick_i    (tmr_tick),
      .expired_o (tmr_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         drain_q      <= '0;
         from_drain_q <= 1'b0;
         halted_q     <= 1'b0;
         busErr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         drain_q      <= drain_d;
         from_drain_q <= from_drain_d;
         halted_q     <= halted_d;
         busErr_q     <= busErr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      from_drain_d = from_drain_q;
      busErr_d     = busErr_q;
      tmr_start    = 1'b0;
      tmr_clear    = 1'b0;
      tmr_tick     = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_miss) begin
               state_d      = MEM_WAIT;
               from_drain_d = 1'b0;
               tmr_start    = 1'b1;
            end else if (haltReq && !flushBranch && !loadUseE) begin
               state_d = DRAIN;
               drain_d = DRAIN_LOAD;
            end
         end
         MEM_WAIT: begin
            // A timeout exits exactly like a completed access, but flags the bus error.
            if (dmemReady || tmr_expired) begin
               state_d   = from_drain_q ? DRAIN : RUN;
               tmr_clear = 1'b1;
               if (!dmemReady) begin
                  busErr_d = 1'b1;
               end
            end else begin
               tmr_tick = 1'b1;
            end
         end
         DRAIN: begin
            if (mem_miss) begin
               state_d      = MEM_WAIT;
               from_drain_d = 1'b1;
               tmr_start    = 1'b1;
            end else if (flushBranch) begin
               drain_d = DRAIN_LOAD;
            end else if (drain_q == '0) begin
               state_d = HALTED;
            end else begin
               drain_d = drain_q - DRN_W'(1);
            end
         end
         HALTED: begin
            if (resumeReq) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
      halted_d = (state_d == HALTED);
   end

   always_comb begin
      ctrl = CTRL_NONE;
      case (state_q)
         RUN: begin
            if (mem_miss) begin
               ctrl = ctrl_mem_freeze();
            end else if (flushBranch) begin
               // The squashed instruction makes any load-use stall moot.
               ctrl.flushD = 1'b1;
               ctrl.flushE = 1'b1;
            end else if (loadUseE) begin
               ctrl.stallF = 1'b1;
               ctrl.stallD = 1'b1;
               ctrl.flushE = 1'b1;
            end else if (haltReq) begin
               ctrl.stallF = 1'b1;
               ctrl.flushD = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (dmemReady) begin
               ctrl = CTRL_NONE;
            end else if (tmr_expired) begin
               ctrl.flushW = 1'b1;
            end else begin
               ctrl = ctrl_mem_freeze();
            end
         end
         DRAIN: begin
            if (mem_miss) begin
               ctrl = ctrl_mem_freeze();
            end else if (flushBranch) begin
               // PC must take the branch target, so fetch is released for this cycle.
               ctrl.flushD = 1'b1;
               ctrl.flushE = 1'b1;
            end else begin
               ctrl.stallF = 1'b1;
               ctrl.flushD = 1'b1;
            end
         end
         HALTED: begin
            ctrl.stallF = 1'b1;
            ctrl.flushD = 1'b1;
         end
         default: ctrl = CTRL_NONE;
      endcase
   end

   assign stallF = ctrl.stallF;
   assign stallD = ctrl.stallD;
   assign stallE = ctrl.stallE;
   assign stallM = ctrl.stallM;
   assign flushD = ctrl.flushD;
   assign flushE = ctrl.flushE;
   assign flushW = ctrl.flushW;
   assign halted = halted_q;
   assign busErr = busErr_q;

`ifdef PIPE_SEQ_PERF_CNT_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (ctrl.stallF) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (ctrl.flushE) begin
            perf_flush_q <= perf_flush_q + 32'd1;
         end
      end
   end

   assign perfStall = perf_stall_q;
   assign perfFlush = perf_flush_q;
`else
   assign perfStall = '0;
   assign perfFlush = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the sequencing rules.
module tb_pipeline_sequencer;

   localparam int PD  = 5;
   localparam int TMO = 4;

   localparam logic [6:0] C_SF = 7'b1000000;
   localparam logic [6:0] C_SD = 7'b0100000;
   localparam logic [6:0] C_SE = 7'b0010000;
   localparam logic [6:0] C_SM = 7'b0001000;
   localparam logic [6:0] C_FD = 7'b0000100;
   localparam logic [6:0] C_FE = 7'b0000010;
   localparam logic [6:0] C_FW = 7'b0000001;
   localparam logic [6:0] FREEZE = C_SF | C_SD | C_SE | C_SM | C_FW;

   logic        clk, rst_n;
   logic        loadUseE, flushBranch, dmemReqM, dmemReady, haltReq, resumeReq;
   logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW;
   logic        halted, busErr;
   logic [31:0] perfStall, perfFlush;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state: drain_left counts remaining drain cycles (0 = not draining).
   bit          m_wait, m_halt, m_err;
   int          m_waited, m_drain_left;
   logic [31:0] m_pstall, m_pflush;

   logic [6:0]  exp_ctrl, obs_ctrl;
   logic        obs_halted, obs_err;
   logic [31:0] obs_pstall, obs_pflush;

   pipeline_sequencer #(
      .PIPE_DEPTH  (PD),
      .MEM_TIMEOUT (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .loadUseE    (loadUseE),
      .flushBranch (flushBranch),
      .dmemReqM    (dmemReqM),
      .dmemReady   (dmemReady),
      .haltReq     (haltReq),
      .resumeReq   (resumeReq),
      .stallF      (stallF),
      .stallD      (stallD),
      .stallE      (stallE),
      .stallM      (stallM),
      .flushD      (flushD),
      .flushE      (flushE),
      .flushW      (flushW),
      .halted      (halted),
      .busErr      (busErr),
      .perfStall   (perfStall),
      .perfFlush   (perfFlush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef PIPE_SEQ_PERF_CNT_EN
      return v;
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_reset();
      m_wait = 0; m_halt = 0; m_err = 0;
      m_waited = 0; m_drain_left = 0;
      m_pstall = '0; m_pflush = '0;
   endtask

   task automatic model_step(input bit lu, fb, req, rdy, hr, rr);
      bit miss;
      miss = req && !rdy;
      exp_ctrl = '0;
      if (m_wait) begin
         if (rdy) m_wait = 0;
         else if (m_waited == TMO) begin exp_ctrl = C_FW; m_err = 1; m_wait = 0; end
         else begin exp_ctrl = FREEZE; m_waited++; end
      end else if (m_halt) begin
         exp_ctrl = C_SF | C_FD;
         if (rr) m_halt = 0;
      end else if (m_drain_left > 0) begin
         if (miss) begin exp_ctrl = FREEZE; m_wait = 1; m_waited = 1; end
         else if (fb) begin exp_ctrl = C_FD | C_FE; m_drain_left = PD - 1; end
         else begin
            exp_ctrl = C_SF | C_FD;
            m_drain_left--;
            if (m_drain_left == 0) m_halt = 1;
         end
      end else begin
         if (miss) begin exp_ctrl = FREEZE; m_wait = 1; m_waited = 1; end
         else if (fb) exp_ctrl = C_FD | C_FE;
         else if (lu) exp_ctrl = C_SF | C_SD | C_FE;
         else if (hr) begin exp_ctrl = C_SF | C_FD; m_drain_left = PD - 1; end
      end
      if (exp_ctrl[6]) m_pstall = m_pstall + 32'd1;
      if (exp_ctrl[1]) m_pflush = m_pflush + 32'd1;
   endtask

   // Applies one cycle of inputs, samples combinational controls mid-cycle and
   // registered outputs just after the edge, and advances the model.
   task automatic run_cycle(input bit lu, fb, req, rdy, hr, rr);
      @(negedge clk);
      loadUseE = lu; flushBranch = fb; dmemReqM = req;
      dmemReady = rdy; haltReq = hr; resumeReq = rr;
      #1;
      obs_ctrl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
      model_step(lu, fb, req, rdy, hr, rr);
      @(posedge clk);
      #1;
      obs_halted = halted; obs_err = busErr;
      obs_pstall = perfStall; obs_pflush = perfFlush;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      {loadUseE, flushBranch, dmemReqM, dmemReady, haltReq, resumeReq} = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      obs_ctrl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
      n_checks++; if (obs_ctrl !== 7'b0) begin n_errors++; $display("FAIL reset_ctrl: got %b want %b", obs_ctrl, 7'b0); end
      n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b want 0", halted); end
      n_checks++; if (busErr !== 1'b0) begin n_errors++; $display("FAIL reset_busErr: got %b want 0", busErr); end
      n_checks++; if (perfStall !== 32'd0 || perfFlush !== 32'd0) begin n_errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perfStall, perfFlush); end
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      run_cycle(1, 0, 0, 0, 0, 0);
      n_checks++; if (obs_ctrl !== (C_SF | C_SD | C_FE)) begin n_errors++; $display("FAIL load_use_ctrl: got %b want %b", obs_ctrl, C_SF | C_SD | C_FE); end
      run_cycle(0, 0, 0, 0, 0, 0);
      n_checks++; if (obs_ctrl !== 7'b0) begin n_errors++; $display("FAIL load_use_release: got %b want %b", obs_ctrl, 7'b0); end
      n_checks++; if (obs_halted !== 1'b0) begin n_errors++; $display("FAIL load_use_halted: got %b want 0", obs_halted); end
   endtask

   task automatic test_branch_over_load_use();
      run_cycle(1, 1, 0, 0, 0, 0);
      n_checks++; if (obs_ctrl !== (C_FD | C_FE)) begin n_errors++; $display("FAIL branch_over_lu: got %b want %b", obs_ctrl, C_FD | C_FE); end
   endtask

   task automatic test_mem_wait();
      for (int i = 0; i < 3; i++) begin
         run_cycle(0, 0, 1, 0, 0, 0);
         n_checks++; if (obs_ctrl !== FREEZE) begin n_errors++; $display("FAIL mem_wait_freeze%0d: got %b want %b", i, obs_ctrl, FREEZE); end
      end
      run_cycle(1, 1, 1, 1, 0, 0);
      n_checks++; if (obs_ctrl !== 7'b0) begin n_errors++; $display("FAIL mem_wait_ready: got %b want %b", obs_ctrl, 7'b0); end
      n_checks++; if (obs_err !== 1'b0) begin n_errors++; $display("FAIL mem_wait_busErr: got %b want 0", obs_err); end
      run_cycle(0, 0, 1, 1, 0, 0);
      n_checks++; if (obs_ctrl !== 7'b0) begin n_errors++; $display("FAIL mem_ready_no_wait: got %b want %b", obs_ctrl, 7'b0); end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < TMO; i++) begin
         run_cycle(0, 0, 1, 0, 0, 0);
         n_checks++; if (obs_ctrl !== FREEZE) begin n_errors++; $display("FAIL timeout_freeze%0d: got %b want %b", i, obs_ctrl, FREEZE); end
         n_checks++; if (obs_err !== 1'b0) begin n_errors++; $display("FAIL timeout_early_err%0d: got %b want 0", i, obs_err); end
      end
      run_cycle(0, 0, 1, 0, 0, 0);
      n_checks++; if (obs_ctrl !== C_FW) begin n_errors++; $display("FAIL timeout_release: got %b want %b", obs_ctrl, C_FW); end
      n_checks++; if (obs_err !== 1'b1) begin n_errors++; $display("FAIL timeout_busErr: got %b want 1", obs_err); end
      for (int i = 0; i < 3; i++) begin
         run_cycle(0, 0, 0, 0, 0, 0);
         n_checks++; if (obs_err !== 1'b1 || obs_ctrl !== 7'b0) begin n_errors++; $display("FAIL busErr_sticky%0d: got err=%b ctrl=%b want err=1 ctrl=0", i, obs_err, obs_ctrl); end
      end
   endtask

   task automatic test_halt_resume();
      run_cycle(0, 0, 0, 0, 1, 0);
      n_checks++; if (obs_ctrl !== (C_SF | C_FD) || obs_halted !== 1'b0) begin n_errors++; $display("FAIL halt_entry: got ctrl=%b halted=%b want ctrl=%b halted=0", obs_ctrl, obs_halted, C_SF | C_FD); end
      for (int i = 1; i <= 4; i++) begin
         run_cycle(0, 0, 0, 0, 0, 0);
         n_checks++; if (obs_halted !== (i == 4)) begin n_errors++; $display("FAIL drain_halted_c%0d: got %b want %b", i, obs_halted, (i == 4)); end
         n_checks++; if (obs_ctrl !== (C_SF | C_FD)) begin n_errors++; $display("FAIL drain_ctrl_c%0d: got %b want %b", i, obs_ctrl, C_SF | C_FD); end
      end
      run_cycle(1, 1, 1, 0, 0, 0);
      n_checks++; if (obs_ctrl !== (C_SF | C_FD) || obs_halted !== 1'b1) begin n_errors++; $display("FAIL halted_hold: got ctrl=%b halted=%b want ctrl=%b halted=1", obs_ctrl, obs_halted, C_SF | C_FD); end
      run_cycle(0, 0, 0, 0, 0, 1);
      n_checks++; if (obs_halted !== 1'b0) begin n_errors++; $display("FAIL resume_halted: got %b want 0", obs_halted); end
      run_cycle(0, 0, 0, 0, 0, 0);
      n_checks++; if (obs_ctrl !== 7'b0) begin n_errors++; $display("FAIL resume_run_ctrl: got %b want %b", obs_ctrl, 7'b0); end
   endtask

   task automatic test_drain_branch();
      logic [31:0] pflush0;
      pflush0 = obs_pflush;
      run_cycle(0, 0, 0, 0, 1, 0);
      run_cycle(0, 0, 0, 0, 0, 0);
      run_cycle(0, 0, 0, 0, 0, 0);
      run_cycle(0, 1, 0, 0, 0, 0);
      n_checks++; if (obs_ctrl !== (C_FD | C_FE)) begin n_errors++; $display("FAIL drain_branch_ctrl: got %b want %b", obs_ctrl, C_FD | C_FE); end
      for (int i = 1; i <= 4; i++) begin
         run_cycle(0, 0, 0, 0, 0, 0);
         n_checks++; if (obs_halted !== (i == 4)) begin n_errors++; $display("FAIL drain_reload_halted_c%0d: got %b want %b", i, obs_halted, (i == 4)); end
      end
      n_checks++; if (obs_pflush - pflush0 !== exp_perf(32'd1)) begin n_errors++; $display("FAIL drain_branch_perfFlush: got delta %0d want %0d", obs_pflush - pflush0, exp_perf(32'd1)); end
   endtask

   task automatic test_resume_beats_halt();
      run_cycle(0, 0, 0, 0, 1, 1);
      n_checks++; if (obs_halted !== 1'b0) begin n_errors++; $display("FAIL resume_wins: got halted=%b want 0", obs_halted); end
      run_cycle(0, 0, 0, 0, 1, 0);
      n_checks++; if (obs_ctrl !== (C_SF | C_FD)) begin n_errors++; $display("FAIL rehalt_entry: got %b want %b", obs_ctrl, C_SF | C_FD); end
   endtask

   task automatic test_mid_reset();
      run_cycle(0, 0, 1, 0, 0, 0);
      n_checks++; if (obs_ctrl !== FREEZE) begin n_errors++; $display("FAIL drain_mem_freeze: got %b want %b", obs_ctrl, FREEZE); end
      run_cycle(0, 0, 1, 0, 0, 0);
      n_checks++; if (obs_err !== 1'b1) begin n_errors++; $display("FAIL pre_reset_busErr: got %b want 1", obs_err); end
      @(negedge clk);
      {loadUseE, flushBranch, dmemReqM, dmemReady, haltReq, resumeReq} = '0;
      rst_n = 1'b0;
      #1;
      obs_ctrl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
      n_checks++; if (obs_ctrl !== 7'b0) begin n_errors++; $display("FAIL mid_reset_ctrl: got %b want %b", obs_ctrl, 7'b0); end
      n_checks++; if (busErr !== 1'b0 || halted !== 1'b0) begin n_errors++; $display("FAIL mid_reset_flags: got busErr=%b halted=%b want 0/0", busErr, halted); end
      n_checks++; if (perfStall !== 32'd0 || perfFlush !== 32'd0) begin n_errors++; $display("FAIL mid_reset_perf: got %0d/%0d want 0/0", perfStall, perfFlush); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      bit lu, fb, req, rdy, hr, rr;
      for (int i = 0; i < 1500; i++) begin
         lu  = ($urandom_range(0, 9) < 2);
         fb  = ($urandom_range(0, 9) < 1);
         req = ($urandom_range(0, 9) < 3);
         rdy = ($urandom_range(0, 4) != 0);
         hr  = ($urandom_range(0, 19) < 1);
         rr  = ($urandom_range(0, 9) < 2);
         run_cycle(lu, fb, req, rdy, hr, rr);
         n_checks++; if (obs_ctrl !== exp_ctrl) begin n_errors++; $display("FAIL rand_ctrl@%0d: got %b want %b", i, obs_ctrl, exp_ctrl); end
         n_checks++; if (obs_halted !== m_halt || obs_err !== m_err) begin n_errors++; $display("FAIL rand_flags@%0d: got halted=%b busErr=%b want %b/%b", i, obs_halted, obs_err, m_halt, m_err); end
         n_checks++; if (obs_pstall !== exp_perf(m_pstall) || obs_pflush !== exp_perf(m_pflush)) begin n_errors++; $display("FAIL rand_perf@%0d: got %0d/%0d want %0d/%0d", i, obs_pstall, obs_pflush, exp_perf(m_pstall), exp_perf(m_pflush)); end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_over_load_use();
      test_mem_wait();
      test_timeout();
      test_halt_resume();
      test_drain_branch();
      test_resume_beats_halt();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
